hls_deadlock_multi_monitor: RTL and testbench

HLS_DEADLOCK_MULTI_MONITOR -- requirements
Module: hls_deadlock_multi_monitor

---
 rtl/hls_deadlock_multi_monitor.sv | 132 +++++++++++++
 tb/tb_hls_deadlock_multi_monitor.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/hls_deadlock_multi_monitor.sv
// Deadlock monitor for HLS designs: qualifies AXIS-channel and sub-instance blocking
// over PERSIST cycles and records the first source, a sticky flag and an event count.
module hls_deadlock_multi_monitor #(
    parameter  int N_AXIS  = 4,
    parameter  int N_INST  = 2,
    parameter  int PERSIST = 4,
    parameter  int CNT_W   = 8,
    localparam int IDX_W   = $clog2(N_AXIS + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_INST-1:0] inst_idle_sigs,
    input  logic [N_INST-1:0] inst_block_sigs,
    input  logic              clear,
    output logic              block,
    output logic              block_sticky,
    output logic [IDX_W-1:0]  block_src,
    output logic [CNT_W-1:0]  block_events
);

    localparam int PW = $clog2(PERSIST + 1);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        BLOCKED
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [PW-1:0]   pcnt;
    logic            inst_dl;
    logic            raw;
    logic            event_hit;
    logic            capture;
    logic [IDX_W-1:0] src_sel;

    // Instance deadlock: nobody is making progress and at least one is stalled.
    assign inst_dl   = (&(inst_idle_sigs | inst_block_sigs)) & (|inst_block_sigs);
    assign raw       = (|axis_block_sigs) | inst_dl;
    assign event_hit = (state_next == BLOCKED) && (state != BLOCKED);
    assign capture   = event_hit && (!block_sticky || clear);

    always_comb begin
        logic found;
        found   = 1'b0;
        src_sel = IDX_W'(N_AXIS);
        for (int unsigned i = 0; i < N_AXIS; i++) begin
            if (axis_block_sigs[i] && !found) begin
                src_sel = IDX_W'(i);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (raw) begin
                    state_next = (PERSIST == 1) ? BLOCKED : PENDING;
                end
            end
            PENDING: begin
                if (!raw) begin
                    state_next = IDLE;
                end else if (pcnt == PW'(PERSIST - 1)) begin
                    state_next = BLOCKED;
                end
            end
            BLOCKED: begin
                if (!raw) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        block = (state == BLOCKED);
    end

    always_ff @(posedge clock) begin
        if (reset || !raw) begin
            pcnt <= '0;
        end else if (pcnt != PW'(PERSIST)) begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // A coincident event wins over clear: the record restarts with this event.
    always_ff @(posedge clock) begin
        if (reset) begin
            block_sticky <= 1'b0;
            block_src    <= '0;
            block_events <= '0;
        end else begin
            if (event_hit) begin
                block_sticky <= 1'b1;
            end else if (clear) begin
                block_sticky <= 1'b0;
            end

            if (capture) begin
                block_src <= src_sel;
            end else if (clear) begin
                block_src <= '0;
            end

            if (event_hit) begin
                if (clear) begin
                    block_events <= CNT_W'(1);
                end else if (block_events != '1) begin
                    block_events <= block_events + CNT_W'(1);
                end
            end else if (clear) begin
                block_events <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hls_deadlock_multi_monitor.sv
// Directed bench: PERSIST=4/CNT_W=2 monitor plus a PERSIST=1 monitor on shared inputs.
module tb_hls_deadlock_multi_monitor;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] axis_block_sigs;
    logic [1:0] inst_idle_sigs;
    logic [1:0] inst_block_sigs;
    logic       clear;

    logic       block;
    logic       block_sticky;
    logic [2:0] block_src;
    logic [1:0] block_events;

    logic       block1;
    logic       block_sticky1;
    logic [2:0] block_src1;
    logic [7:0] block_events1;

    int total = 0;
    int bad   = 0;

    hls_deadlock_multi_monitor #(
        .N_AXIS (4),
        .N_INST (2),
        .PERSIST(4),
        .CNT_W  (2)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .clear          (clear),
        .block          (block),
        .block_sticky   (block_sticky),
        .block_src      (block_src),
        .block_events   (block_events)
    );

    hls_deadlock_multi_monitor #(
        .N_AXIS (4),
        .N_INST (2),
        .PERSIST(1),
        .CNT_W  (8)
    ) dut1 (
        .clock          (clock),
        .reset          (reset),
        .axis_block_sigs(axis_block_sigs),
        .inst_idle_sigs (inst_idle_sigs),
        .inst_block_sigs(inst_block_sigs),
        .clear          (clear),
        .block          (block1),
        .block_sticky   (block_sticky1),
        .block_src      (block_src1),
        .block_events   (block_events1)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Hold axis pattern until qualified, then release; one event per call.
    task automatic axis_event(input logic [3:0] pat);
        axis_block_sigs = pat;
        ticks(4);
        check("ev_block", 32'(block), 32'd1);
        axis_block_sigs = '0;
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        clear           = 1'b0;
        axis_block_sigs = '0;
        inst_idle_sigs  = '0;
        inst_block_sigs = '0;
        ticks(2);
        check("rst_block",  32'(block),        32'd0);
        check("rst_sticky", 32'(block_sticky), 32'd0);
        check("rst_src",    32'(block_src),    32'd0);
        check("rst_events", 32'(block_events), 32'd0);
        check("rst_sticky1", 32'(block_sticky1), 32'd0);
        check("rst_src1",    32'(block_src1),    32'd0);
        check("rst_events1", 32'(block_events1), 32'd0);
        reset = 1'b0;
        tick();
        check("idle_block", 32'(block), 32'd0);

        // Short glitch: 3 cycles of raw is below PERSIST=4.
        axis_block_sigs = 4'b0001;
        tick();
        check("p1_follow_raw", 32'(block1), 32'd1);
        ticks(2);
        check("glitch_block", 32'(block), 32'd0);
        axis_block_sigs = '0;
        tick();
        check("glitch_block_after", 32'(block),        32'd0);
        check("glitch_sticky",      32'(block_sticky), 32'd0);
        check("glitch_events",      32'(block_events), 32'd0);
        check("p1_drop",            32'(block1),       32'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;

        // Held axis block on channel 2.
        axis_block_sigs = 4'b0100;
        ticks(3);
        check("axis_pre_block", 32'(block), 32'd0);
        tick();
        check("axis_block",  32'(block),        32'd1);
        check("axis_src",    32'(block_src),    32'd2);
        check("axis_events", 32'(block_events), 32'd1);
        check("axis_sticky", 32'(block_sticky), 32'd1);
        ticks(3);
        check("axis_hold_events", 32'(block_events), 32'd1);
        axis_block_sigs = '0;
        tick();
        check("axis_fall",   32'(block),        32'd0);
        check("axis_sticky_hold", 32'(block_sticky), 32'd1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_sticky", 32'(block_sticky), 32'd0);
        check("clr_src",    32'(block_src),    32'd0);
        check("clr_events", 32'(block_events), 32'd0);

        // All idle, none blocked: not a deadlock.
        inst_idle_sigs  = 2'b11;
        inst_block_sigs = 2'b00;
        ticks(5);
        check("all_idle_block", 32'(block), 32'd0);

        // Instance deadlock: inst0 idle, inst1 blocked.
        inst_idle_sigs  = 2'b01;
        inst_block_sigs = 2'b10;
        ticks(3);
        check("inst_pre_block", 32'(block), 32'd0);
        tick();
        check("inst_block",  32'(block),        32'd1);
        check("inst_src",    32'(block_src),    32'd4);
        check("inst_events", 32'(block_events), 32'd1);
        inst_idle_sigs = 2'b00;
        tick();
        check("inst_fall",   32'(block),        32'd0);
        check("inst_sticky", 32'(block_sticky), 32'd1);
        inst_block_sigs = 2'b00;
        tick();

        // Four more events: count saturates at 3, src keeps first source.
        for (int e = 2; e <= 5; e++) begin
            axis_event(4'b1000);
            check("sat_events", 32'(block_events), (e > 3) ? 32'd3 : 32'(e));
        end
        check("sat_src", 32'(block_src), 32'd4);

        // Clear coincident with the transition into BLOCKED.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        axis_event(4'b1000);
        axis_event(4'b1000);
        check("pre_coinc_events", 32'(block_events), 32'd2);
        check("pre_coinc_src",    32'(block_src),    32'd3);
        axis_block_sigs = 4'b0100;
        ticks(3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("coinc_block",  32'(block),        32'd1);
        check("coinc_events", 32'(block_events), 32'd1);
        check("coinc_sticky", 32'(block_sticky), 32'd1);
        check("coinc_src",    32'(block_src),    32'd2);

        // Clear while blocked leaves the FSM alone.
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_blk_block",  32'(block),        32'd1);
        check("clr_blk_sticky", 32'(block_sticky), 32'd0);
        check("clr_blk_events", 32'(block_events), 32'd0);
        check("clr_blk_src",    32'(block_src),    32'd0);

        // Reset mid-BLOCKED with raw held, then requalify.
        clear = 1'b1;
        reset = 1'b1;
        tick();
        check("mid_rst_block",  32'(block),        32'd0);
        check("mid_rst_sticky", 32'(block_sticky), 32'd0);
        check("mid_rst_events", 32'(block_events), 32'd0);
        check("mid_rst_block1", 32'(block1),       32'd0);
        reset = 1'b0;
        clear = 1'b0;
        tick();
        check("rel_block1", 32'(block1), 32'd1);
        ticks(2);
        check("rel_pre_block", 32'(block), 32'd0);
        tick();
        check("rel_block",  32'(block),        32'd1);
        check("rel_events", 32'(block_events), 32'd1);
        check("rel_src",    32'(block_src),    32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
